mult_bw_mac: RTL and testbench
==============================

Name: mult_bw_mac

Overview:
- Pipelined Baugh-Wooley multiply-accumulate unit; next generation of the plain signed multiplier in parts/mult_baugh_wooley.
- Adds per-transaction operand signedness, an optional running accumulator with overflow flag, and valid/ready backpressure.
- Sits between sample-producing datapath blocks and correlator/finder logic that need sums of products.

Parameters:
- A_WIDTH, 8, width of operand in_A (>=2)
- B_WIDTH, 6, width of operand in_B (>=2)
- GUARD_BITS, 4, extra accumulator bits above the A_WIDTH+B_WIDTH product (>=0)
- ACC_WIDTH, A_WIDTH+B_WIDTH+GUARD_BITS, derived (localparam), accumulator/output width

Ports:
- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair present
- in_ready  output  1  block accepts operands this cycle
- in_A  input  A_WIDTH  operand A
- in_B  input  B_WIDTH  operand B
- in_signed_A  input  1  1 = in_A is two's complement, 0 = unsigned
- in_signed_B  input  1  1 = in_B is two's complement, 0 = unsigned
- in_acc  input  1  1 = add product to running sum, 0 = start a new sum with this product
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts the result
- out_C  output  ACC_WIDTH  signed result
- out_ovf  output  1  signed overflow occurred when forming this out_C

Behaviour:
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - in_A, in_B, in_signed_A, in_signed_B and in_acc are sampled together on an input transfer.
- Latency and throughput:
  - SMALLER_WIDTH = min(A_WIDTH, B_WIDTH); NUM_LAYERS = $clog2(SMALLER_WIDTH).
  - Stage 0 generates the Baugh-Wooley partial products, with the sign-row correction selected by the signed flags.
  - NUM_LAYERS registered reduction layers follow.
  - A final stage performs the final add and the accumulate.
  - LATENCY = NUM_LAYERS + 2 cycles from input transfer to out_valid, with no stall (5 for the defaults).
  - Throughput is one transaction per cycle.
- Arithmetic:
  - An unsigned operand is treated as zero-extended by one bit; a signed operand is treated as sign-extended.
  - The product P is exact in A_WIDTH+B_WIDTH bits for all four sign combinations.
  - P is sign-extended to ACC_WIDTH if either operand is signed; otherwise it is zero-extended.
- Accumulator:
  - The accumulator register ACC holds the last out_C.
  - Final stage: in_acc=0 gives out_C = P; in_acc=1 gives out_C = ACC + P.
  - Overflow wraps modulo 2^ACC_WIDTH.
  - out_ovf = 1 when ACC and P have the same sign and the sum's sign differs; out_ovf = 0 whenever in_acc = 0.
  - ACC updates only when a result enters the output register, never while the pipeline is stalled.
- Backpressure (global stall):
  - stall = out_valid && !out_ready; in_ready = !stall (combinational).
  - While stalled, every pipeline register, valid bit and ACC holds its value.
  - out_C and out_ovf stay stable while out_valid && !out_ready.
  - Bubbles are not collapsed: in-flight items keep their spacing.
- Reset:
  - On reset=1 at a clock edge: all stage valid bits = 0, out_valid = 0, out_C = 0, out_ovf = 0, ACC = 0.
  - in_ready = 1 from the first cycle after reset.
  - Reset mid-operation discards all in-flight transactions; nothing is emitted for them.
  - Inputs presented in the reset cycle are ignored.
- Boundary conditions:
  - in_acc=1 on the first transaction after reset accumulates onto ACC=0.
  - Simultaneous output transfer and new input transfer is legal every cycle.
  - in_valid=0 inserts bubbles; ACC is unaffected by bubbles.
  - Most-negative operands (e.g. -128 x -32) produce the exact positive product with no overflow.

Test Plan:
1. Defaults, reset 2 cycles, then one transfer in_A=3, in_B=-2, both signed, in_acc=0 -> out_valid exactly 5 cycles after the transfer, out_C=-6, out_ovf=0.
2. Sign modes on in_A=8'hFF, in_B=6'h3F: unsigned/unsigned -> 16065; signed/signed -> 1; signed A/unsigned B -> -63; unsigned A/signed B -> -255. Issue back-to-back, one per cycle -> four results on consecutive cycles in order.
3. Accumulate in_A=5, in_B=7 signed, with in_acc=0,1,1 -> out_C = 35, 70, 105. A fourth transaction with in_acc=0, in_A=-1, in_B=1 -> out_C=-1.
4. Overflow: 32 transactions of in_A=-128, in_B=-32 signed, in_acc=1 after the first -> 31st out_C=126976, out_ovf=0; 32nd out_C=-131072, out_ovf=1.
5. Backpressure: stream 8 transactions with out_ready held 0 for cycles 3-7 -> in_ready=0 during the stall, out_C/out_valid stable, all 8 results delivered in order, none lost or duplicated.
6. Reset mid-flight: issue 3 transactions, assert reset 2 cycles after the first -> no out_valid for any of them; ACC=0, so a following in_acc=1, 2x3 transaction -> out_C=6.

Source files
------------

// File: rtl/mult_bw_mac.sv
`default_nettype none
// ============================================================================
//  Module   : mult_bw_mac
//  Purpose  : Pipelined Baugh-Wooley multiply-accumulate unit. Each operand
//             carries its own signedness flag; results can start a new sum
//             or add onto the previous result, with a signed overflow flag.
//             A single global stall freezes the whole pipeline whenever the
//             output register holds a result that downstream has not taken.
//  Ports    : clk          - clock, rising edge
//             reset        - synchronous, active-high
//             in_valid     - operand pair present
//             in_ready     - operands accepted this cycle (= not stalled)
//             in_A, in_B   - operands
//             in_signed_A  - 1: in_A is two's complement, 0: unsigned
//             in_signed_B  - 1: in_B is two's complement, 0: unsigned
//             in_acc       - 1: add product onto last result, 0: new sum
//             out_valid    - result present
//             out_ready    - downstream accepts the result
//             out_C        - signed result, A_WIDTH+B_WIDTH+GUARD_BITS bits
//             out_ovf      - signed overflow when forming this out_C
//  Revision : 1.0 - initial release
// ============================================================================
module mult_bw_mac #(
   parameter int A_WIDTH    = 8,
   parameter int B_WIDTH    = 6,
   parameter int GUARD_BITS = 4
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic [A_WIDTH-1:0]                     in_A,
   input  logic [B_WIDTH-1:0]                     in_B,
   input  logic                                   in_signed_A,
   input  logic                                   in_signed_B,
   input  logic                                   in_acc,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [A_WIDTH+B_WIDTH+GUARD_BITS-1:0]  out_C,
   output logic                                   out_ovf
);

   localparam int ACC_WIDTH     = A_WIDTH + B_WIDTH + GUARD_BITS;
   localparam int PROD_WIDTH    = A_WIDTH + B_WIDTH;
   localparam int SMALLER_WIDTH = (A_WIDTH < B_WIDTH) ? A_WIDTH : B_WIDTH;
   localparam int LARGER_WIDTH  = (A_WIDTH < B_WIDTH) ? B_WIDTH : A_WIDTH;
   localparam int NUM_LAYERS    = $clog2(SMALLER_WIDTH);

   // Every inverted partial-product bit of weight 2^w contributes an extra
   // +2^w that must be removed again. These are the three groups of such
   // bits: X sign column, Y sign row, and the shared sign-by-sign bit.
   localparam logic [PROD_WIDTH-1:0] C_ONE     = PROD_WIDTH'(1);
   localparam logic [PROD_WIDTH-1:0] C_CORR_X  =
      ((C_ONE << (SMALLER_WIDTH-1)) - C_ONE) << (LARGER_WIDTH-1);
   localparam logic [PROD_WIDTH-1:0] C_CORR_Y  =
      ((C_ONE << (LARGER_WIDTH-1)) - C_ONE) << (SMALLER_WIDTH-1);
   localparam logic [PROD_WIDTH-1:0] C_CORR_XY = C_ONE << (PROD_WIDTH-2);

   // -------------------------------------------------------------------------
   // Operand steering: partial-product rows are formed over the narrower
   // operand (Y) so the reduction tree has SMALLER_WIDTH rows.
   // -------------------------------------------------------------------------
   logic [LARGER_WIDTH-1:0]  op_x;
   logic [SMALLER_WIDTH-1:0] op_y;
   logic                     sgn_x;
   logic                     sgn_y;

   generate
      if (A_WIDTH >= B_WIDTH) begin : g_rows_over_b
         assign op_x  = in_A;
         assign op_y  = in_B;
         assign sgn_x = in_signed_A;
         assign sgn_y = in_signed_B;
      end else begin : g_rows_over_a
         assign op_x  = in_B;
         assign op_y  = in_A;
         assign sgn_x = in_signed_B;
         assign sgn_y = in_signed_A;
      end
   endgenerate

   // A bit is inverted when its term carries a negative weight: the X sign
   // column (if X signed), the Y sign row (if Y signed), and the corner bit
   // when exactly one operand is signed.
   function automatic logic inv_bit(input int i, input int j,
                                    input logic sx, input logic sy);
      logic res;
      if (j == SMALLER_WIDTH-1) begin
         res = (i == LARGER_WIDTH-1) ? (sx ^ sy) : sy;
      end else begin
         res = (i == LARGER_WIDTH-1) ? sx : 1'b0;
      end
      return res;
   endfunction

   // -------------------------------------------------------------------------
   // Stage 0: Baugh-Wooley partial products
   // -------------------------------------------------------------------------
   logic [PROD_WIDTH-1:0] pp [SMALLER_WIDTH];

   always_comb begin
      for (int j = 0; j < SMALLER_WIDTH; j++) begin
         pp[j] = '0;
         for (int i = 0; i < LARGER_WIDTH; i++) begin
            pp[j][i+j] = (op_x[i] & op_y[j]) ^ inv_bit(i, j, sgn_x, sgn_y);
         end
      end
   end

   // -------------------------------------------------------------------------
   // Reduction tree. rows_q[0] holds the partial products, rows_q[l] the
   // result of layer l. Each layer adds rows pairwise; slots past the live
   // row count are zero. The last layer always has at most two live rows.
   // -------------------------------------------------------------------------
   logic [PROD_WIDTH-1:0] rows_d [NUM_LAYERS][SMALLER_WIDTH];
   logic [PROD_WIDTH-1:0] rows_q [NUM_LAYERS][SMALLER_WIDTH];
   logic [PROD_WIDTH-1:0] sum_d;
   logic [PROD_WIDTH-1:0] sum_q;

   generate
      for (genvar r = 0; r < SMALLER_WIDTH; r++) begin : g_stage0
         assign rows_d[0][r] = pp[r];
      end
      for (genvar l = 1; l < NUM_LAYERS; l++) begin : g_layer
         for (genvar r = 0; r < SMALLER_WIDTH; r++) begin : g_row
            if (2*r+1 < SMALLER_WIDTH) begin : g_pair
               assign rows_d[l][r] = rows_q[l-1][2*r] + rows_q[l-1][2*r+1];
            end else if (2*r < SMALLER_WIDTH) begin : g_pass
               assign rows_d[l][r] = rows_q[l-1][2*r];
            end else begin : g_zero
               assign rows_d[l][r] = '0;
            end
         end
      end
   endgenerate

   assign sum_d = rows_q[NUM_LAYERS-1][0] + rows_q[NUM_LAYERS-1][1];

   // Per-stage side-band: index 0 is stage 0, index NUM_LAYERS the last layer.
   logic [NUM_LAYERS:0] valid_d, valid_q;
   logic [NUM_LAYERS:0] sx_d, sx_q;
   logic [NUM_LAYERS:0] sy_d, sy_q;
   logic [NUM_LAYERS:0] acc_d, acc_q;

   assign valid_d = {valid_q[NUM_LAYERS-1:0], in_valid};
   assign sx_d    = {sx_q[NUM_LAYERS-1:0], sgn_x};
   assign sy_d    = {sy_q[NUM_LAYERS-1:0], sgn_y};
   assign acc_d   = {acc_q[NUM_LAYERS-1:0], in_acc};

   // -------------------------------------------------------------------------
   // Final stage: correction, extension, accumulate. out_c_q doubles as the
   // accumulator since it always holds the last result.
   // -------------------------------------------------------------------------
   logic                  out_valid_d, out_valid_q;
   logic [ACC_WIDTH-1:0]  out_c_d, out_c_q;
   logic                  out_ovf_d, out_ovf_q;
   logic [PROD_WIDTH-1:0] corr;
   logic [PROD_WIDTH-1:0] prod;
   logic [ACC_WIDTH-1:0]  prod_ext;
   logic [ACC_WIDTH-1:0]  acc_sum;
   logic                  stall;

   always_comb begin
      corr = '0;
      if (sx_q[NUM_LAYERS]) begin
         corr = corr + C_CORR_X;
      end
      if (sy_q[NUM_LAYERS]) begin
         corr = corr + C_CORR_Y;
      end
      if (sx_q[NUM_LAYERS] ^ sy_q[NUM_LAYERS]) begin
         corr = corr + C_CORR_XY;
      end
      prod = sum_q - corr;

      if (sx_q[NUM_LAYERS] | sy_q[NUM_LAYERS]) begin
         prod_ext = ACC_WIDTH'($signed(prod));
      end else begin
         prod_ext = ACC_WIDTH'(prod);
      end
      acc_sum = out_c_q + prod_ext;

      out_valid_d = valid_q[NUM_LAYERS];
      out_c_d     = out_c_q;
      out_ovf_d   = out_ovf_q;
      if (valid_q[NUM_LAYERS]) begin
         if (acc_q[NUM_LAYERS]) begin
            out_c_d   = acc_sum;
            out_ovf_d = (out_c_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                        (acc_sum[ACC_WIDTH-1] != out_c_q[ACC_WIDTH-1]);
         end else begin
            out_c_d   = prod_ext;
            out_ovf_d = 1'b0;
         end
      end
   end

   assign stall     = out_valid_q & ~out_ready;
   assign in_ready  = ~stall;
   assign out_valid = out_valid_q;
   assign out_C     = out_c_q;
   assign out_ovf   = out_ovf_q;

   // Control and result state (reset).
   always_ff @(posedge clk) begin : p_ctrl
      if (reset) begin
         valid_q     <= '0;
         out_valid_q <= 1'b0;
         out_c_q     <= '0;
         out_ovf_q   <= 1'b0;
      end else if (!stall) begin
         valid_q     <= valid_d;
         out_valid_q <= out_valid_d;
         out_c_q     <= out_c_d;
         out_ovf_q   <= out_ovf_d;
      end
   end

   // Datapath state; qualified by the valid bits, so no reset needed.
   always_ff @(posedge clk) begin : p_data
      if (!stall) begin
         rows_q <= rows_d;
         sum_q  <= sum_d;
         sx_q   <= sx_d;
         sy_q   <= sy_d;
         acc_q  <= acc_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mult_bw_mac.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_bw_mac
//  Purpose  : Self-checking bench for mult_bw_mac. Stimulus pushes expected
//             results from an arithmetic reference model into a scoreboard;
//             a monitor pops and compares on every output transfer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult_bw_mac;

   localparam int A_W   = 8;
   localparam int B_W   = 6;
   localparam int G_W   = 4;
   localparam int ACC_W = A_W + B_W + G_W;
   localparam int LAT   = 5;
   localparam longint MAXV = (longint'(1) <<< (ACC_W-1)) - 1;
   localparam longint MINV = -(longint'(1) <<< (ACC_W-1));

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [A_W-1:0]   in_A = '0;
   logic [B_W-1:0]   in_B = '0;
   logic             in_signed_A = 1'b0;
   logic             in_signed_B = 1'b0;
   logic             in_acc = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [ACC_W-1:0] out_C;
   logic             out_ovf;

   mult_bw_mac #(.A_WIDTH(A_W), .B_WIDTH(B_W), .GUARD_BITS(G_W)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_A(in_A), .in_B(in_B),
      .in_signed_A(in_signed_A), .in_signed_B(in_signed_B), .in_acc(in_acc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_C(out_C), .out_ovf(out_ovf)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [ACC_W-1:0] c;
      logic             ovf;
      int               cyc;
      bit               chk_lat;
   } exp_t;

   exp_t   scb[$];
   longint m_acc = 0;
   int     n_tests = 0;
   int     n_fail = 0;
   int     bp_mode = 0;   // 0: ready, 1: hold off, 2: random

   task automatic chk(input string name, input longint act, input longint req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference model: plain integer arithmetic on the operand values.
   task automatic model_push(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                             input logic sa, input logic sb, input logic acc,
                             input bit lat);
      longint av, bv, p, s;
      logic [ACC_W-1:0] w;
      exp_t e;
      av = sa ? longint'($signed(a)) : longint'(a);
      bv = sb ? longint'($signed(b)) : longint'(b);
      p  = av * bv;
      s  = acc ? (m_acc + p) : p;
      e.ovf = acc && ((s > MAXV) || (s < MINV));
      w = s[ACC_W-1:0];
      m_acc = longint'($signed(w));
      e.c = w;
      e.cyc = cyc;
      e.chk_lat = lat;
      scb.push_back(e);
   endtask

   task automatic send(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                       input logic sa, input logic sb, input logic acc,
                       input bit lat);
      bit accepted = 0;
      in_valid = 1'b1; in_A = a; in_B = b;
      in_signed_A = sa; in_signed_B = sb; in_acc = acc;
      for (int w = 0; w < 100; w++) begin
         @(negedge clk);
         if (in_ready) begin
            accepted = 1;
            model_push(a, b, sa, sb, acc, lat);
         end
         @(posedge clk); #1;
         if (accepted) break;
      end
      in_valid = 1'b0;
      if (!accepted) chk("send_timeout", 0, 1);
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      in_valid = 1'b1;                // presented during reset: must be ignored
      in_A = A_W'($urandom); in_B = B_W'($urandom); in_acc = 1'b1;
      scb.delete();
      m_acc = 0;
      repeat (n) @(posedge clk);
      #1;
      reset = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      bit done = 0;
      for (int w = 0; w < 300; w++) begin
         @(negedge clk);
         if (scb.size() == 0) begin
            done = 1;
            break;
         end
      end
      if (!done) chk("drain_timeout", scb.size(), 0);
      @(posedge clk); #1;
   endtask

   // Downstream ready driver.
   initial begin
      forever begin
         @(posedge clk); #2;
         case (bp_mode)
            1:       out_ready = 1'b0;
            2:       out_ready = ($urandom_range(0, 2) != 0);
            default: out_ready = 1'b1;
         endcase
      end
   end

   // Monitor: handshake rule, stall stability, scoreboard compare.
   initial begin
      logic [ACC_W-1:0] prev_c;
      logic             prev_ovf;
      bit               prev_stall;
      exp_t             e;
      prev_stall = 0; prev_c = '0; prev_ovf = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_stall = 0;
         end else begin
            chk("in_ready", in_ready, !(out_valid && !out_ready));
            if (prev_stall) begin
               chk("hold_valid", out_valid, 1);
               chk("hold_C", out_C, prev_c);
               chk("hold_ovf", out_ovf, prev_ovf);
            end
            if (out_valid && out_ready) begin
               if (scb.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_out: got out_C=%0d, expected no result (cycle %0d)",
                           $signed(out_C), cyc);
               end else begin
                  e = scb.pop_front();
                  chk("out_C", longint'($signed(out_C)), longint'($signed(e.c)));
                  chk("out_ovf", out_ovf, e.ovf);
                  if (e.chk_lat) chk("latency", cyc - e.cyc, LAT);
               end
            end
            prev_stall = out_valid && !out_ready;
            prev_c     = out_C;
            prev_ovf   = out_ovf;
         end
      end
   end

   task automatic chk_reset_state();
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_C", out_C, 0);
      chk("rst_out_ovf", out_ovf, 0);
      chk("rst_in_ready", in_ready, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1: single signed transfer, latency
      do_reset(2);
      chk_reset_state();
      send(8'd3, 6'h3E, 1'b1, 1'b1, 1'b0, 1'b1);
      drain();

      // 2: sign modes, back-to-back
      send(8'hFF, 6'h3F, 1'b0, 1'b0, 1'b0, 1'b1);
      send(8'hFF, 6'h3F, 1'b1, 1'b1, 1'b0, 1'b1);
      send(8'hFF, 6'h3F, 1'b1, 1'b0, 1'b0, 1'b1);
      send(8'hFF, 6'h3F, 1'b0, 1'b1, 1'b0, 1'b1);
      drain();

      // 3: accumulate, then restart
      send(8'd5, 6'd7, 1'b1, 1'b1, 1'b0, 1'b1);
      send(8'd5, 6'd7, 1'b1, 1'b1, 1'b1, 1'b1);
      send(8'd5, 6'd7, 1'b1, 1'b1, 1'b1, 1'b1);
      send(8'hFF, 6'd1, 1'b1, 1'b1, 1'b0, 1'b1);
      drain();

      // 4: most-negative operands accumulated into overflow
      for (int i = 0; i < 32; i++) begin
         send(8'h80, 6'h20, 1'b1, 1'b1, (i != 0), 1'b1);
      end
      drain();

      // 5: backpressure window during an 8-item stream
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               send(A_W'(i * 17 + 3), B_W'(i * 5 + 1), 1'b1, i[0], (i != 0), 1'b0);
            end
         end
         begin
            repeat (3) @(posedge clk);
            #1 bp_mode = 1;
            repeat (5) @(posedge clk);
            #1 bp_mode = 0;
         end
      join
      drain();

      // 6: reset mid-flight discards in-flight work, ACC returns to zero
      send(8'd9, 6'd9, 1'b0, 1'b0, 1'b1, 1'b0);
      send(8'd10, 6'd4, 1'b1, 1'b1, 1'b1, 1'b0);
      send(8'd11, 6'd3, 1'b0, 1'b1, 1'b1, 1'b0);
      do_reset(2);
      chk_reset_state();
      send(8'd2, 6'd3, 1'b1, 1'b1, 1'b1, 1'b1);
      drain();

      // 7: random traffic with bubbles and random backpressure
      bp_mode = 2;
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end else begin
            send(A_W'($urandom), B_W'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) != 0), 1'b0);
         end
      end
      bp_mode = 0;
      drain();
      repeat (10) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
